// File: rtl/pwm_sel_if.sv
// Signal bundle between the PWM selector controller and its environment:
// the button/enable inputs, the decoder mask return path and the frame outputs.
interface pwm_sel_if;
  logic       ena;
  logic       btn_up;
  logic       btn_dn;
  logic [4:0] h;
  logic [2:0] s;
  logic [2:0] slot;
  logic       pwm;
  logic       frame_start;
  logic       sel_changed;

  modport master (
    output ena, btn_up, btn_dn, h,
    input  s, slot, pwm, frame_start, sel_changed
  );

  modport slave (
    input  ena, btn_up, btn_dn, h,
    output s, slot, pwm, frame_start, sel_changed
  );
endinterface

// File: rtl/pwm_sel_ctrl.sv
// Debounced up/down duty selector plus a 5-slot PWM frame sequencer.
// The selector is applied only at frame entry, so the waveform never glitches mid-frame.
module pwm_sel_ctrl #(
    parameter int DEB_CYCLES  = 16,
    parameter int SLOT_CYCLES = 4,
    parameter int SEL_MAX     = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    pwm_sel_if.slave bus
);

    localparam int DEB_W  = $clog2(DEB_CYCLES);
    localparam int SLOT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOT_CYCLES - 1);
    localparam logic [2:0]        SEL_TOP   = 3'(SEL_MAX);
    localparam logic [2:0]        LAST_SLOT = 3'd4;

    typedef enum logic {IDLE, RUN} state_t;

    // Button index 0 is "up", index 1 is "down".
    logic [1:0]       raw;
    logic [1:0]       sync1;
    logic [1:0]       sync2;
    logic [1:0]       deb;
    logic [1:0]       press;
    logic [DEB_W-1:0] deb_cnt [2];

    state_t            state;
    state_t            state_nxt;
    logic              frame_entry;
    logic              slot_tc;
    logic [SLOT_W-1:0] slot_cnt;
    logic [2:0]        slot;
    logic [2:0]        s;
    logic [2:0]        s_pending;
    logic              frame_start;
    logic              sel_changed;
    logic [7:0]        h_ext;

    assign raw = {bus.btn_dn, bus.btn_up};

    // NOTE: sequential state always uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, independent of block order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            deb <= '0;
            for (int i = 0; i < 2; i++) deb_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] != deb[i]) begin
                    if (deb_cnt[i] == DEB_LAST) begin
                        deb[i]     <= sync2[i];
                        deb_cnt[i] <= '0;
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + 1'b1;
                    end
                end else begin
                    deb_cnt[i] <= '0;
                end
            end
        end
    end

    // A press is the cycle in which a debounced level is about to flip 0->1.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            press[i] = sync2[i] && !deb[i] && (deb_cnt[i] == DEB_LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    assign slot_tc = (slot_cnt == SLOT_LAST);

    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_nxt   = state;
        frame_entry = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.ena) begin
                    state_nxt   = RUN;
                    frame_entry = 1'b1;
                end
            end
            RUN: begin
                if (!bus.ena) begin
                    state_nxt = IDLE;
                end else if (slot_tc && slot == LAST_SLOT) begin
                    frame_entry = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot_cnt    <= '0;
            slot        <= '0;
            s           <= '0;
            frame_start <= 1'b0;
            sel_changed <= 1'b0;
        end else begin
            frame_start <= frame_entry;
            sel_changed <= frame_entry && (s_pending != s);
            if (frame_entry) s <= s_pending;

            if (state_nxt == IDLE || frame_entry) begin
                slot_cnt <= '0;
                slot     <= '0;
            end else if (slot_tc) begin
                slot_cnt <= '0;
                slot     <= (slot == LAST_SLOT) ? 3'd0 : slot + 3'd1;
            end else begin
                slot_cnt <= slot_cnt + 1'b1;
            end
        end
    end

    // Simultaneous up and down presses cancel each other.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_pending <= '0;
        end else begin
            unique case (press)
                2'b01:   if (s_pending < SEL_TOP) s_pending <= s_pending + 3'd1;
                2'b10:   if (s_pending != 3'd0)   s_pending <= s_pending - 3'd1;
                default: s_pending <= s_pending;
            endcase
        end
    end

    // Widened so the slot index always lands inside the vector.
    assign h_ext = {3'b000, bus.h};

    assign bus.s           = s;
    assign bus.slot        = slot;
    assign bus.frame_start = frame_start;
    assign bus.sel_changed = sel_changed;
    assign bus.pwm         = (state == RUN) && h_ext[slot];

endmodule

// File: tb/tb_pwm_sel_ctrl.sv
// Bench for pwm_sel_ctrl: directed scenarios then random button/enable activity,
// compared every cycle against a frame-position reference model.
module tb_pwm_sel_ctrl;

    localparam int DEB     = 4;
    localparam int SLOT    = 2;
    localparam int FRAME   = 5 * SLOT;
    localparam int SEL_MAX = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    pwm_sel_if bus ();

    // Stand-in for decod_conf: s ones from bit 0 upward, plus bit 0 always set.
    assign bus.h = 5'((6'd2 << bus.s) - 6'd1);

    pwm_sel_ctrl #(
        .DEB_CYCLES (DEB),
        .SLOT_CYCLES(SLOT),
        .SEL_MAX    (SEL_MAX)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Reference model: run flag, position within the frame, selector values.
    bit m_run;
    int m_pos;
    int m_s, m_pend, m_fs, m_sc;
    bit up_q[$];
    bit dn_q[$];
    bit acc[2];
    int run_len[2];

    // Raw level seen two cycles late; accepted after DEB consecutive disagreements.
    function automatic bit debounce(int i, bit seen);
        bit pressed = 1'b0;
        if (seen != acc[i]) begin
            run_len[i]++;
            if (run_len[i] == DEB) begin
                acc[i]     = seen;
                run_len[i] = 0;
                pressed    = seen;
            end
        end else begin
            run_len[i] = 0;
        end
        return pressed;
    endfunction

    task automatic model_edge();
        bit up_seen, dn_seen, pu, pd, entry;
        if (!rst_n) begin
            m_run = 0; m_pos = 0; m_s = 0; m_pend = 0; m_fs = 0; m_sc = 0;
            up_q = '{1'b0, 1'b0};
            dn_q = '{1'b0, 1'b0};
            acc = '{1'b0, 1'b0};
            run_len = '{0, 0};
            return;
        end
        up_seen = up_q.pop_front();
        dn_seen = dn_q.pop_front();
        up_q.push_back(bus.btn_up);
        dn_q.push_back(bus.btn_dn);
        pu = debounce(0, up_seen);
        pd = debounce(1, dn_seen);

        entry = 1'b0;
        if (!m_run) begin
            if (bus.ena) begin
                m_run = 1; m_pos = 0; entry = 1'b1;
            end
        end else if (!bus.ena) begin
            m_run = 0;
        end else begin
            m_pos = (m_pos + 1) % FRAME;
            entry = (m_pos == 0);
        end
        m_fs = entry;
        m_sc = entry && (m_pend != m_s);
        if (entry) m_s = m_pend;

        if (pu && !pd && m_pend < SEL_MAX) m_pend++;
        if (pd && !pu && m_pend > 0)       m_pend--;
    endtask

    task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s at %0t: observed %0d expected %0d", tag, $time, obs, exp);
        end
    endtask

    task automatic compare_all();
        int exp_slot;
        exp_slot = m_run ? m_pos / SLOT : 0;
        chk("s", 8'(bus.s), 8'(m_s));
        chk("slot", 8'(bus.slot), 8'(exp_slot));
        chk("pwm", 8'(bus.pwm), 8'(m_run && exp_slot <= m_s));
        chk("frame_start", 8'(bus.frame_start), 8'(m_fs));
        chk("sel_changed", 8'(bus.sel_changed), 8'(m_sc));
        chk("s_pending", 8'(dut.s_pending), 8'(m_pend));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_edge();
        compare_all();
    endtask

    task automatic hold(int n);
        repeat (n) step();
    endtask

    task automatic run_to_slot(int k);
        for (int i = 0; i < 3 * FRAME; i++) begin
            if (m_run && m_pos == k * SLOT) break;
            step();
        end
    endtask

    task automatic press(bit up);
        if (up) bus.btn_up = 1'b1; else bus.btn_dn = 1'b1;
        hold(DEB + 4);
        if (up) bus.btn_up = 1'b0; else bus.btn_dn = 1'b0;
        hold(DEB + 4);
    endtask

    initial begin
        bus.ena    = 1'b1;
        bus.btn_up = 1'b0;
        bus.btn_dn = 1'b0;

        // Reset held while enabled and a button chatters.
        for (int i = 0; i < 3; i++) begin
            step();
            bus.btn_up = ~bus.btn_up;
        end
        bus.btn_up = 1'b0;
        rst_n = 1'b1;

        // Default duty, then reset in slot 3.
        hold(2 * FRAME + 3);
        run_to_slot(3);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        hold(FRAME);

        // Held up button during slot 2 yields a single step.
        run_to_slot(2);
        bus.btn_up = 1'b1;
        hold(20);
        bus.btn_up = 1'b0;
        hold(2 * FRAME);

        // Saturate upward, then drain past zero.
        for (int i = 0; i < 6; i++) press(1'b1);
        hold(2 * FRAME);
        for (int i = 0; i < 6; i++) press(1'b0);
        hold(2 * FRAME);

        // Short glitch, then simultaneous press and release.
        bus.btn_up = 1'b1;
        hold(2);
        bus.btn_up = 1'b0;
        hold(FRAME);
        bus.btn_up = 1'b1;
        bus.btn_dn = 1'b1;
        hold(12);
        bus.btn_up = 1'b0;
        bus.btn_dn = 1'b0;
        hold(2 * FRAME);

        // Disable mid-frame, press while idle, re-enable.
        run_to_slot(3);
        bus.ena = 1'b0;
        step();
        press(1'b1);
        bus.ena = 1'b1;
        hold(2 * FRAME);

        // Random button chatter, enable toggling and occasional reset.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(5) == 0) bus.btn_up = ~bus.btn_up;
            if ($urandom_range(5) == 0) bus.btn_dn = ~bus.btn_dn;
            if ($urandom_range(39) == 0) bus.ena = ~bus.ena;
            rst_n = ($urandom_range(199) != 0);
            step();
        end
        rst_n = 1'b1;
        hold(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pwm_sel_ctrl.md
Name: pwm_sel_ctrl

Overview:
Configuration controller and frame sequencer for the PWM duty decoder. It debounces two user buttons (up/down) into a saturating 3-bit duty selector `s`, which drives the decod_conf input. It walks a 5-slot PWM frame and outputs `pwm = h[slot]` from the decoder's 5-bit thermometer mask. Selector changes take effect only at frame boundaries, so the PWM waveform never glitches mid-frame.

Parameters:
- DEB_CYCLES, 16, consecutive stable synchronized-input cycles required to accept a new button level (min 2).
- SLOT_CYCLES, 4, clock cycles per PWM slot (min 1); one frame = 5*SLOT_CYCLES cycles.
- SEL_MAX, 4, upper saturation value of the selector (s=4 gives 100 % duty).

Ports:
- clk  input  1  system clock, all logic rising-edge.
- rst_n  input  1  reset, synchronous, active-low.
- ena  input  1  run enable; 0 forces IDLE.
- btn_up  input  1  raw asynchronous increment button, active-high.
- btn_dn  input  1  raw asynchronous decrement button, active-high.
- h  input  5  thermometer mask returned by decod_conf(s).
- s  output  3  registered selector to decod_conf.
- slot  output  3  registered current slot index, 0..4.
- pwm  output  1  PWM output.
- frame_start  output  1  one-cycle pulse on the first cycle of each frame.
- sel_changed  output  1  one-cycle pulse when `s` takes a new value.

Behaviour:
- Reset (rst_n=0 at a clk edge): `s`=0, `s_pending`=0, `slot`=0, slot-cycle counter=0, `frame_start`=0, `sel_changed`=0, `pwm`=0, FSM=IDLE. Synchronizers, debounce counters and debounced levels all clear to 0. Reset takes priority over every other event, including mid-frame and mid-debounce.
- Input path: each button passes through a 2-flop synchronizer.
  - Each button has its own debounce counter. When the synchronized level differs from the debounced level, the counter increments; otherwise it clears.
  - When the counter reaches DEB_CYCLES, the debounced level flips and the counter clears.
  - A 0->1 flip of the debounced level emits a one-cycle press pulse.
  - Press latency = DEB_CYCLES+2 cycles after a stable raw rise. A held button gives exactly one press (no auto-repeat).
- Pending selector:
  - up press: `s_pending` = min(`s_pending`+1, SEL_MAX).
  - dn press: `s_pending` = max(`s_pending`-1, 0).
  - Both presses in the same cycle: no change.
  - Presses are accepted in IDLE and RUN alike.
- FSM states:
  - IDLE: `slot`=0, counter=0, `pwm`=0. `ena`=1 moves to RUN.
  - RUN: `ena`=0 returns to IDLE on the next edge. `s_pending` and `s` are kept.
- Frame sequencing (RUN):
  - The counter counts 0..SLOT_CYCLES-1. At terminal count, `slot` advances 0->1->2->3->4->0.
  - Frame entry is the edge that puts the block in slot 0, counter 0. This is either IDLE->RUN or the wrap from slot 4 at terminal count.
  - On frame entry: `s` <= `s_pending` and `frame_start` <= 1. `sel_changed` <= 1 iff `s_pending` != `s`. The new `s` is therefore valid during the frame_start cycle.
  - `frame_start` and `sel_changed` are high for exactly one cycle. `s` is otherwise constant within a frame.
- PWM output:
  - `pwm` = (state==RUN) & h[`slot`], combinational from registered `slot`/`s` through the decoder. No extra latency.
  - Expected duty with decod_conf: s=0 1/5, s=1 2/5, s=2 3/5, s=3 4/5, s=4 5/5.
- `slot` never leaves 0..4. `s` never exceeds SEL_MAX.

Test Plan (DEB_CYCLES=4, SLOT_CYCLES=2, frame=10 cycles, real decod_conf attached):
1. Reset: rst_n=0 for 3 cycles while ena=1 and btn_up toggles every cycle -> s=0, slot=0, pwm=0, frame_start=0, sel_changed=0. Repeat with rst_n=0 asserted mid-frame (slot=3) -> same values next edge.
2. Default duty: ena=1 after reset -> frame_start on the first RUN cycle, then every 10 cycles; pwm high 2 of 10 cycles (slot 0 only).
3. Single increment: btn_up held 20 cycles during slot 2 -> s_pending=1 after 6 cycles. s stays 0 until the next frame entry, then s=1 with sel_changed=1 in the frame_start cycle; pwm high 4 of 10 cycles. Held button yields exactly one step.
4. Saturation: six separated up presses -> s reaches 4, pwm constant 1 across frames. Then five dn presses plus one extra -> s=0, with no underflow to 7.
5. Glitch and conflict: btn_up high 2 cycles -> no press, s unchanged. btn_up and btn_dn rising together and held -> no change in s_pending, sel_changed stays 0.
6. Enable: ena=0 at slot 3 -> next cycle pwm=0, slot=0, s retained. An up press while disabled, then ena=1 -> first RUN cycle has frame_start=1, s=old+1, sel_changed=1.
